// File: rtl/alu_74181_serial.sv
// Slice-serial 74181-style ALU: operands are captured through a valid/ready
// handshake, then processed SLICE bits per clock, LSB slice first.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in_valid/ready command handshake (a, b, s, m, cin captured on accept)
//   out_valid/ready result handshake (f, cout, ovf, aeqb held while valid)
//   busy           high while an operation is running or awaiting pickup
module alu_74181_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             aeqb,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             aeqb_q, aeqb_d;

  logic [SLICE-1:0] sa, sb, sf;
  logic             x, y, c, c_msb;
  logic             slice_cout, slice_cmsb;
  logic             last;

  assign last = (cnt_q == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      aeqb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      aeqb_q  <= aeqb_d;
    end
  end

  // One 74181 slice: select operands by counter, ripple the carry through.
  always_comb begin
    sa = '0;
    sb = '0;
    sf = '0;
    x = 1'b0;
    y = 1'b0;
    c = carry_q;
    c_msb = carry_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    for (int j = 0; j < SLICE; j++) begin
      x = sa[j] | (sb[j] & s_q[0]) | (~sb[j] & s_q[1]);
      y = (sa[j] & ~sb[j] & s_q[2]) | (sa[j] & sb[j] & s_q[3]);
      sf[j] = m_q ? ~(x ^ y) : (x ^ y ^ c);
      if (j == SLICE - 1) c_msb = c;
      c = (x & y) | (c & (x ^ y));
    end
    // Logic mode has no carry chain.
    slice_cout = m_q ? 1'b0 : c;
    slice_cmsb = m_q ? 1'b0 : c_msb;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    aeqb_d  = aeqb_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (cnt_q == CW'(i)) f_d[i*SLICE +: SLICE] = sf;
        end
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d = slice_cout;
          ovf_d  = slice_cmsb ^ slice_cout;
          aeqb_d = &f_d;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    f         = f_q;
    cout      = cout_q;
    ovf       = ovf_q;
    aeqb      = aeqb_q;
  end

endmodule

// File: tb/tb_alu_74181_serial.sv
// Directed bench for alu_74181_serial (WIDTH=16, SLICE=4).
// Drives commands through the handshake and checks results and flags.
module tb_alu_74181_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  s;
  logic        m;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        cout;
  logic        ovf;
  logic        aeqb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_74181_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .ovf(ovf), .aeqb(aeqb),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command, wait for out_valid, optionally pick up the result.
  task automatic do_op(
    input  logic [15:0] ia, input logic [15:0] ib,
    input  logic [3:0] is, input logic im, input logic ic,
    input  bit release_res,
    output logic [15:0] rf, output logic rc,
    output logic ro, output logic re, output int lat
  );
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got %0b want 1", in_ready);
    end
    a = ia; b = ib; s = is; m = im; cin = ic;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout got %0b want 1", out_valid);
    end
    rf = f; rc = cout; ro = ovf; re = aeqb;
    if (release_res) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 001", {out_valid, busy, in_ready});
    end
    checks++;
    if ({f, cout, ovf, aeqb} !== 19'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {f, cout, ovf, aeqb});
    end
  endtask

  task automatic test_add;
    logic [15:0] rf; logic rc, ro, re; int lat;
    do_op(16'h00FF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    checks++;
    if ({rf, rc, ro, re} !== {16'h0100, 3'b000}) begin
      errors++;
      $display("FAIL add got %h/%b%b%b want 0100/000", rf, rc, ro, re);
    end
  endtask

  task automatic test_compare;
    logic [15:0] rf; logic rc, ro, re; int lat;
    do_op(16'h1234, 16'h1234, 4'd6, 1'b0, 1'b0, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if ({rf, re, rc} !== {16'hFFFF, 2'b10}) begin
      errors++;
      $display("FAIL cmp_eq got %h aeqb %b cout %b want FFFF 1 0", rf, re, rc);
    end
    do_op(16'h1234, 16'h1234, 4'd6, 1'b0, 1'b1, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if ({rf, re, rc} !== {16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL cmp_cin got %h aeqb %b cout %b want 0000 0 1", rf, re, rc);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] rf; logic rc, ro, re; int lat;
    do_op(16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if ({rf, ro, rc} !== {16'h8000, 2'b10}) begin
      errors++;
      $display("FAIL ovf got %h ovf %b cout %b want 8000 1 0", rf, ro, rc);
    end
    do_op(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if ({rf, ro, rc} !== {16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL wrap got %h ovf %b cout %b want 0000 0 1", rf, ro, rc);
    end
  endtask

  task automatic test_arith;
    logic [15:0] rf; logic rc, ro, re; int lat;
    // A-1 with carry out, A+A with overflow, A-B via cin, plain A.
    logic [15:0] ta [4] = '{16'h0005, 16'h8001, 16'h0005, 16'h4321};
    logic [15:0] tb [4] = '{16'h0000, 16'h0000, 16'h0003, 16'hAAAA};
    logic [3:0]  ts [4] = '{4'd15, 4'd12, 4'd6, 4'd0};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] ef [4] = '{16'h0004, 16'h0002, 16'h0002, 16'h4321};
    logic        ec [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], ts[i], 1'b0, tc[i], 1'b1, rf, rc, ro, re, lat);
      checks++;
      if ({rf, rc, ro} !== {ef[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL arith_s%0d got %h c%b o%b want %h c%b o%b",
                 ts[i], rf, rc, ro, ef[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_logic_sweep;
    logic [15:0] rf; logic rc, ro, re; int lat;
    logic [15:0] exp_f [16] = '{
      16'h0F0F, 16'h000F, 16'h0F00, 16'h0000,
      16'h0FFF, 16'h00FF, 16'h0FF0, 16'h00F0,
      16'hFF0F, 16'hF00F, 16'hFF00, 16'hF000,
      16'hFFFF, 16'hF0FF, 16'hFFF0, 16'hF0F0};
    for (int i = 0; i < 16; i++) begin
      do_op(16'hF0F0, 16'hFF00, 4'(i), 1'b1, 1'b1, 1'b1,
            rf, rc, ro, re, lat);
      checks++;
      if ({rf, rc, ro, re} !== {exp_f[i], 2'b00, (i == 12)}) begin
        errors++;
        $display("FAIL logic_s%0d got %h c%b o%b e%b want %h 0 0 %0d",
                 i, rf, rc, ro, re, exp_f[i], (i == 12));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] rf; logic rc, ro, re; int lat;
    do_op(16'h1111, 16'h2222, 4'd9, 1'b0, 1'b0, 1'b0, rf, rc, ro, re, lat);
    a = 16'hDEAD; b = 16'hBEEF; s = 4'd3; m = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({f, cout, ovf, aeqb, out_valid, in_ready, busy} !==
          {16'h3333, 3'b000, 3'b101}) begin
        errors++;
        $display("FAIL hold_%0d got %h %b%b%b v%b r%b b%b want 3333 000 v1 r0 b1",
                 k, f, cout, ovf, aeqb, out_valid, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy, f} !== {3'b010, 16'h3333}) begin
      errors++;
      $display("FAIL release got v%b r%b b%b f %h want v0 r1 b0 3333",
               out_valid, in_ready, busy, f);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rf; logic rc, ro, re; int lat;
    do_op(16'h0003, 16'h0004, 4'd9, 1'b0, 1'b0, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1", in_ready);
    end
    do_op(16'h0010, 16'h0001, 4'd6, 1'b0, 1'b1, 1'b1, rf, rc, ro, re, lat);
    checks++;
    if ({rf, rc, lat} !== {16'h000F, 1'b1, 32'd4}) begin
      errors++;
      $display("FAIL b2b_second got %h c%b lat %0d want 000F c1 lat 4",
               rf, rc, lat);
    end
  endtask

  task automatic test_reset_mid;
    a = 16'h00FF; b = 16'h0001; s = 4'd9; m = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_run got b%b r%b want b1 r0", busy, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready, f} !== {3'b001, 16'h0000}) begin
      errors++;
      $display("FAIL mid_reset got v%b b%b r%b f %h want v0 b0 r1 0000",
               out_valid, busy, in_ready, f);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ghost_%0d got %b want 0", k, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_add();
    test_compare();
    test_overflow();
    test_arith();
    test_logic_sweep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
